bram_frame_writer_nin: RTL and testbench
========================================

// Module: bram_frame_writer_nin
// PURPOSE
//  Joins NUM_IN valid/ready streams into one packed word and writes one full frame,
//  in raster order, into one of NUM_BANKS frame buffers. It sits after the disparity
//  filter stages and feeds the frame BRAMs: one write per beat, one beat per cycle at
//  full throughput. It replaces the 2-input writer, which wrote at most every other cycle.
// PARAMETERS
//  NUM_IN      2                       number of input streams (>=1)
//  CH_WIDTH    8                       bits per input stream
//  WIDTH       120                     frame width, pixels
//  HEIGHT      240                     frame height, pixels
//  FRAME_SIZE  WIDTH*HEIGHT            beats per frame
//  ADDR_BITS   $clog2(FRAME_SIZE)      write address width
//  NUM_BANKS   2                       frame buffers (>=2)
//  BANK_BITS   $clog2(NUM_BANKS)       bank index width
//  AUTO_TOGGLE 1                       1: bank advances per completed frame; 0: bank_sel_in used
// PORTS
//  clk          in   1                    clock
//  reset        in   1                    synchronous, active-high
//  in_data      in   NUM_IN*CH_WIDTH      stream i occupies bits [i*CH_WIDTH +: CH_WIDTH]
//  in_valid     in   NUM_IN               per-stream valid
//  in_ready     out  NUM_IN               per-stream ready
//  start        in   1                    begin a frame (honoured only in IDLE)
//  abort        in   1                    cancel the current frame
//  bank_sel_in  in   BANK_BITS            target bank when AUTO_TOGGLE=0
//  idle         out  1                    state==IDLE
//  frame_done   out  1                    1-cycle pulse when the last beat is written
//  wr_bank      out  BANK_BITS            bank being written
//  wr_data      out  NUM_IN*CH_WIDTH      packed word = in_data
//  wr_address   out  ADDR_BITS            BRAM address
//  wr_ena       out  1                    write strobe
//  stall_count  out  16                   see CONFIGURATION
// BEHAVIOUR
//  - States: IDLE, RUNNING.
//  - IDLE->RUNNING on start && !abort. On entry, wr_address<=0.
//  - On entry with AUTO_TOGGLE=0: wr_bank<=bank_sel_in. With AUTO_TOGGLE=1, wr_bank is kept.
//  - fire = RUNNING && &in_valid. The handshake is joint.
//  - in_ready[i] = fire, for every i. A stream is never consumed alone.
//  - wr_ena = fire. wr_data = in_data. Both are combinational: zero latency, no buffering.
//  - On fire with wr_address < FRAME_SIZE-1: wr_address++.
//  - On fire with wr_address == FRAME_SIZE-1: frame_done=1 (registered, next cycle) and
//    state->IDLE.
//  - At that completion, with AUTO_TOGGLE=1: wr_bank <= (wr_bank==NUM_BANKS-1) ? 0 : wr_bank+1.
//  - start while RUNNING is ignored, including on the last-beat cycle. The next frame needs
//    start in IDLE, so the minimum gap is 1 idle cycle.
//  - abort while RUNNING: state->IDLE and wr_address<=0. There is no frame_done and wr_bank
//    does not advance. If abort and fire coincide, the write still occurs; abort wins the
//    state update.
//  - abort && start in IDLE: the block stays in IDLE.
//  - Partial valid, i.e. some but not all valid: no fire, no ready, address held.
//  - Reset values: state=IDLE, wr_address=0, wr_bank=0, frame_done=0, stall_count=0.
//  - Reset mid-frame discards the frame. wr_ena and in_ready are 0 from the cycle after reset.
// CONFIGURATION
//  WRITER_STALL_CNT_EN defined:
//   - stall_count is a 16-bit counter, saturating at 16'hFFFF.
//   - It increments on each RUNNING cycle where |in_valid && !&in_valid (input skew).
//   - It clears on IDLE->RUNNING and on reset. It holds its value in IDLE.
//  WRITER_STALL_CNT_EN undefined:
//   - stall_count is tied to 16'd0 and no counter logic is built.
// TESTING
//  (NUM_IN=2, CH_WIDTH=8, WIDTH=4, HEIGHT=2, NUM_BANKS=2, AUTO_TOGGLE=1)
//  1. start, both valid held high 8 cycles, data a=i b=8'h10+i -> wr_ena 8 consecutive
//     cycles, addr 0..7, wr_data={8'h10+i,i}, frame_done 1 cycle after addr 7, idle.
//  2. Second start after test 1 -> wr_bank=1; third frame -> wr_bank=0 (wrap).
//  3. in_valid=2'b01 for 3 cycles mid-frame -> no wr_ena, in_ready=0, addr held;
//     stall_count=3 with WRITER_STALL_CNT_EN, 0 without.
//  4. abort at addr 5 -> idle next cycle, no frame_done, wr_bank unchanged; restart
//     writes from addr 0.
//  5. start pulsed on the last-beat cycle -> ignored; start+abort in IDLE -> stays IDLE.
//  6. reset asserted at addr 3 -> all outputs at reset values next cycle; AUTO_TOGGLE=0
//     with bank_sel_in=1 -> wr_bank=1 for the frame.

Source files
------------

// File: rtl/bram_frame_writer_nin.sv
// Joins NUM_IN valid/ready streams into one packed word and writes a raster-order frame
// into one of NUM_BANKS BRAM frame buffers. Optional skew counter: WRITER_STALL_CNT_EN.
module bram_frame_writer_nin #(
  parameter int NUM_IN      = 2,
  parameter int CH_WIDTH    = 8,
  parameter int WIDTH       = 120,
  parameter int HEIGHT      = 240,
  parameter int FRAME_SIZE  = WIDTH * HEIGHT,
  parameter int ADDR_BITS   = $clog2(FRAME_SIZE),
  parameter int NUM_BANKS   = 2,
  parameter int BANK_BITS   = $clog2(NUM_BANKS),
  parameter int AUTO_TOGGLE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_IN*CH_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]          in_valid,
  output logic [NUM_IN-1:0]          in_ready,
  input  logic                       start,
  input  logic                       abort,
  input  logic [BANK_BITS-1:0]       bank_sel_in,
  output logic                       idle,
  output logic                       frame_done,
  output logic [BANK_BITS-1:0]       wr_bank,
  output logic [NUM_IN*CH_WIDTH-1:0] wr_data,
  output logic [ADDR_BITS-1:0]       wr_address,
  output logic                       wr_ena,
  output logic [15:0]                stall_count
);

  typedef enum logic {IDLE, RUNNING} state_t;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FRAME_SIZE - 1);
  localparam logic [BANK_BITS-1:0] LAST_BANK = BANK_BITS'(NUM_BANKS - 1);

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [BANK_BITS-1:0]   bank_q, bank_d;
  logic                   done_q, done_d;
  logic                   fire;

  // All streams are consumed together, so the write happens only when every one is valid.
  assign fire       = (state_q == RUNNING) && (&in_valid);
  assign in_ready   = {NUM_IN{fire}};
  assign wr_ena     = fire;
  assign wr_data    = in_data;
  assign wr_address = addr_q;
  assign wr_bank    = bank_q;
  assign frame_done = done_q;
  assign idle       = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUNNING;
          addr_d  = '0;
          if (AUTO_TOGGLE == 0) bank_d = bank_sel_in;
        end
      end
      RUNNING: begin
        if (fire) begin
          if (addr_q == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (AUTO_TOGGLE != 0) bank_d = (bank_q == LAST_BANK) ? '0 : bank_q + 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
        // Abort overrides completion: the write still lands but the frame is not counted.
        if (abort) begin
          state_d = IDLE;
          addr_d  = '0;
          done_d  = 1'b0;
          bank_d  = bank_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      bank_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      done_q  <= done_d;
    end
  end

`ifdef WRITER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Counts running cycles where the input streams are skewed (some but not all valid).
  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && start && !abort) begin
      stall_d = '0;
    end else if ((state_q == RUNNING) && (|in_valid) && !(&in_valid) && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_bram_frame_writer_nin.sv
// Directed bench for bram_frame_writer_nin on a 4x2 frame; a second instance with
// AUTO_TOGGLE=0 shares the inputs to cover externally selected banks.
module tb_bram_frame_writer_nin;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic [1:0]  in_valid;
  logic        start;
  logic        abort;
  logic        bank_sel_in;
  logic [1:0]  in_ready, in_ready2;
  logic        idle, idle2, frame_done, frame_done2;
  logic        wr_bank, wr_bank2;
  logic [15:0] wr_data, wr_data2;
  logic [2:0]  wr_address, wr_address2;
  logic        wr_ena, wr_ena2;
  logic [15:0] stall_count, stall_count2;

  int total = 0;
  int bad   = 0;

`ifdef WRITER_STALL_CNT_EN
  localparam int EXP_STALL = 3;
`else
  localparam int EXP_STALL = 0;
`endif

  always #5 clk = ~clk;

  bram_frame_writer_nin #(
    .NUM_IN(2), .CH_WIDTH(8), .WIDTH(4), .HEIGHT(2), .NUM_BANKS(2), .AUTO_TOGGLE(1)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .start(start), .abort(abort), .bank_sel_in(bank_sel_in), .idle(idle),
    .frame_done(frame_done), .wr_bank(wr_bank), .wr_data(wr_data),
    .wr_address(wr_address), .wr_ena(wr_ena), .stall_count(stall_count)
  );

  bram_frame_writer_nin #(
    .NUM_IN(2), .CH_WIDTH(8), .WIDTH(4), .HEIGHT(2), .NUM_BANKS(2), .AUTO_TOGGLE(0)
  ) dut2 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
    .start(start), .abort(abort), .bank_sel_in(bank_sel_in), .idle(idle2),
    .frame_done(frame_done2), .wr_bank(wr_bank2), .wr_data(wr_data2),
    .wr_address(wr_address2), .wr_ena(wr_ena2), .stall_count(stall_count2)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before checking.
  task automatic apply_stimulus(input logic s, input logic a, input logic [1:0] v,
                                input logic [15:0] d);
    @(negedge clk);
    start    = s;
    abort    = a;
    in_valid = v;
    in_data  = d;
    #1;
  endtask

  function automatic logic [15:0] beat_data(input int i);
    return {8'(16 + i), 8'(i)};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 2'b00;
    in_data = 16'h0; bank_sel_in = 1'b0;
    repeat (2) @(posedge clk);
    apply_stimulus(0, 0, 2'b00, 16'h0);
    reset = 1'b0;
    check_output("rst_idle", 32'(idle), 32'd1);
    check_output("rst_addr", 32'(wr_address), 32'd0);
    check_output("rst_bank", 32'(wr_bank), 32'd0);
    check_output("rst_done", 32'(frame_done), 32'd0);
    check_output("rst_stall", 32'(stall_count), 32'd0);
    check_output("rst_ena", 32'(wr_ena), 32'd0);
    check_output("rst_ready", 32'(in_ready), 32'd0);

    // Frame 1: full-throughput beats into bank 0
    apply_stimulus(1, 0, 2'b00, 16'h0);
    check_output("f1_idle_before", 32'(idle), 32'd1);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(0, 0, 2'b11, beat_data(i));
      check_output("f1_ena", 32'(wr_ena), 32'd1);
      check_output("f1_addr", 32'(wr_address), 32'(i));
      check_output("f1_data", 32'(wr_data), 32'(beat_data(i)));
      check_output("f1_ready", 32'(in_ready), 32'd3);
      check_output("f1_bank", 32'(wr_bank), 32'd0);
      check_output("f1_done_low", 32'(frame_done), 32'd0);
    end
    apply_stimulus(0, 0, 2'b00, 16'h0);
    check_output("f1_done", 32'(frame_done), 32'd1);
    check_output("f1_idle", 32'(idle), 32'd1);
    check_output("f1_ena_off", 32'(wr_ena), 32'd0);
    check_output("f1_bank_next", 32'(wr_bank), 32'd1);
    apply_stimulus(0, 0, 2'b00, 16'h0);
    check_output("f1_done_pulse", 32'(frame_done), 32'd0);

    // Frame 2: bank 1, three skewed cycles mid-frame
    apply_stimulus(1, 0, 2'b00, 16'h0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 2'b11, beat_data(i));
      check_output("f2_addr", 32'(wr_address), 32'(i));
      check_output("f2_bank", 32'(wr_bank), 32'd1);
    end
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, 0, 2'b01, beat_data(3));
      check_output("skew_ena", 32'(wr_ena), 32'd0);
      check_output("skew_ready", 32'(in_ready), 32'd0);
      check_output("skew_addr", 32'(wr_address), 32'd3);
    end
    for (int i = 3; i < 8; i++) begin
      apply_stimulus(0, 0, 2'b11, beat_data(i));
      check_output("f2_addr", 32'(wr_address), 32'(i));
      if (i == 3) check_output("skew_stall", 32'(stall_count), 32'(EXP_STALL));
    end
    apply_stimulus(0, 0, 2'b00, 16'h0);
    check_output("f2_done", 32'(frame_done), 32'd1);
    check_output("f2_bank_wrap", 32'(wr_bank), 32'd0);
    apply_stimulus(0, 0, 2'b00, 16'h0);
    check_output("stall_hold_idle", 32'(stall_count), 32'(EXP_STALL));

    // Frame 3: abort at address 5 while a beat is firing
    apply_stimulus(1, 0, 2'b00, 16'h0);
    for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 2'b11, beat_data(i));
    apply_stimulus(0, 1, 2'b11, beat_data(5));
    check_output("abort_write", 32'(wr_ena), 32'd1);
    check_output("abort_addr", 32'(wr_address), 32'd5);
    apply_stimulus(0, 0, 2'b00, 16'h0);
    check_output("abort_idle", 32'(idle), 32'd1);
    check_output("abort_no_done", 32'(frame_done), 32'd0);
    check_output("abort_bank", 32'(wr_bank), 32'd0);
    check_output("abort_addr_clr", 32'(wr_address), 32'd0);

    // Restart, with start pulsed again on the last beat
    apply_stimulus(1, 0, 2'b00, 16'h0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus((i == 7) ? 1'b1 : 1'b0, 0, 2'b11, beat_data(i));
      check_output("rs_addr", 32'(wr_address), 32'(i));
      if (i == 0) check_output("rs_stall_clr", 32'(stall_count), 32'd0);
    end
    apply_stimulus(0, 0, 2'b00, 16'h0);
    check_output("rs_done", 32'(frame_done), 32'd1);
    check_output("rs_idle", 32'(idle), 32'd1);
    check_output("rs_bank", 32'(wr_bank), 32'd1);
    apply_stimulus(1, 1, 2'b00, 16'h0);
    check_output("late_start_ignored", 32'(idle), 32'd1);
    apply_stimulus(0, 0, 2'b00, 16'h0);
    check_output("start_abort_idle", 32'(idle), 32'd1);

    // Reset mid-frame at address 3
    apply_stimulus(1, 0, 2'b00, 16'h0);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 2'b11, beat_data(i));
    apply_stimulus(0, 0, 2'b11, beat_data(3));
    check_output("pre_rst_addr", 32'(wr_address), 32'd3);
    reset = 1'b1;
    apply_stimulus(0, 0, 2'b11, beat_data(4));
    reset = 1'b0;
    check_output("mid_rst_idle", 32'(idle), 32'd1);
    check_output("mid_rst_addr", 32'(wr_address), 32'd0);
    check_output("mid_rst_bank", 32'(wr_bank), 32'd0);
    check_output("mid_rst_done", 32'(frame_done), 32'd0);
    check_output("mid_rst_stall", 32'(stall_count), 32'd0);
    check_output("mid_rst_ena", 32'(wr_ena), 32'd0);
    check_output("mid_rst_ready", 32'(in_ready), 32'd0);
    check_output("mid_rst_bank2", 32'(wr_bank2), 32'd0);

    // External bank select on the AUTO_TOGGLE=0 instance
    bank_sel_in = 1'b1;
    apply_stimulus(1, 0, 2'b00, 16'h0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(0, 0, 2'b11, beat_data(i));
      if (i == 0) begin
        check_output("sel_bank2", 32'(wr_bank2), 32'd1);
        check_output("sel_bank_auto", 32'(wr_bank), 32'd0);
      end
      check_output("sel_addr2", 32'(wr_address2), 32'(i));
    end
    apply_stimulus(0, 0, 2'b00, 16'h0);
    check_output("sel_done2", 32'(frame_done2), 32'd1);
    check_output("sel_bank2_kept", 32'(wr_bank2), 32'd1);
    check_output("sel_bank_auto_adv", 32'(wr_bank), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
